demux_l1_sched: RTL and testbench
=================================

# demux_l1_sched

Selector scheduler for the layer-1 1:2 demux pair (two 8-bit lanes feeding four output lanes). Runs on `clk_2f`, alternates the shared demux selector on every accepted word, gates lane valids when the destination pair is back-pressured, and realigns the selector to 0 after an idle gap. It sits between the upstream lane sources and the layer-1 demux; data buses bypass it, only control passes through.

## Interface
Parameters:
- `IDLE_TO`, default 4: consecutive idle cycles in ACTIVE before returning to IDLE (range 1–15).
- `CNT_W`, default 8: width of the routed-word counters.

Ports:
- `clk_2f`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `valid0`  in  1  upstream lane 0 word present.
- `valid1`  in  1  upstream lane 1 word present.
- `pause0`..`pause3`  in  1 each  almost-full from downstream output lanes 0..3.
- `selectorL1`  out  1  demux selector (0 → outputs 0/2, 1 → outputs 1/3).
- `validg0`  out  1  gated valid to demux lane 0.
- `validg1`  out  1  gated valid to demux lane 1.
- `stall`  out  1  to upstream: hold current words, they were not accepted.
- `cnt_sel0`  out  CNT_W  words routed with selector 0.
- `cnt_sel1`  out  CNT_W  words routed with selector 1.

## Operation
- Registers: `state` (IDLE, ACTIVE, HOLD), `sel_q`, idle counter `idle_q` (4 bits), `cnt_sel0/1`.
- `selectorL1 = sel_q`.
- `blocked = sel_q ? (pause1 | pause3) : (pause0 | pause2)`.
- `any_v = valid0 | valid1`; `accept = any_v & ~blocked`.
- `validg0 = valid0 & ~blocked`, `validg1 = valid1 & ~blocked`; `stall = any_v & blocked`. All combinational from registered state and current inputs.
- On `accept`: `sel_q` toggles; `cnt_selX` (X = `sel_q` before toggle) increments by 1, wrapping at 2^CNT_W−1 → 0.
- Both lanes valid in the same cycle count as one accepted word (one increment, one toggle).
- FSM:
  - IDLE: `sel_q` forced 0. `accept` → ACTIVE. `any_v & blocked` → HOLD.
  - ACTIVE: `accept` → stay and clear `idle_q`. `any_v & blocked` → HOLD. `~any_v` → increment `idle_q`; when `idle_q == IDLE_TO−1` → IDLE, `sel_q` ← 0, `idle_q` ← 0.
  - HOLD: `sel_q` frozen. When `blocked` clears: with `any_v` → ACTIVE (word accepted that cycle); without `any_v` → ACTIVE. HOLD never times out to IDLE, so the selector is never realigned while a word is pending.
- Pause changing mid-HOLD to the other pair does not matter; only the pair selected by `sel_q` is examined.

## Timing
- Reset (`reset` high at an edge): `state` = IDLE, `sel_q` = 0, `idle_q` = 0, `cnt_sel0` = `cnt_sel1` = 0. `validg0/1` and `stall` follow their equations with `sel_q` = 0. While `reset` is high, `validg0/1` and `stall` are forced 0.
- Zero-cycle latency from valid/pause to `validg*`/`stall`. One-cycle latency from accept to the new `selectorL1`.
- Reset asserted mid-HOLD: the pending word is dropped from the controller's view; upstream must re-present it.
- Upstream handshake rule: a word is consumed in the cycle where its valid is high and `stall` is low.

## Configuration
- `DEMUX_L1_SCHED_CNT_EN` defined: `cnt_sel0/1` are implemented as described.
- Not defined: counter registers are removed, and `cnt_sel0/1` are tied to 0. FSM and selector behaviour are identical either way.

## Structure
- Shared package `demux_l1_pkg`: state encoding constants (IDLE = 2'd0, ACTIVE = 2'd1, HOLD = 2'd2) and the default `IDLE_TO`.
- One natural sub-module, `demux_l1_idle_timer`: the idle counter with clear and increment inputs and a `timeout` output. The top level holds the FSM, selector and counters.

## Test plan
- Reset, then `valid0` = `valid1` = 1 for 4 cycles with no pause: `selectorL1` = 0, 1, 0, 1; `cnt_sel0` = 2, `cnt_sel1` = 2; `stall` stays 0.
- With `sel_q` = 1, assert `pause3` for 3 cycles while `valid0` = 1: `validg0` = 0, `stall` = 1, state is HOLD, `selectorL1` holds at 1. Drop `pause3`: the word is accepted and the selector becomes 0 the next cycle.
- Accept one word (`sel_q` → 1), then 4 idle cycles with `IDLE_TO` = 4: state returns to IDLE and `selectorL1` = 0. Next valid routes with selector 0.
- `pause0` asserted while `sel_q` = 1 and valid present: no stall, word accepted (off-pair pause ignored).
- Preload `cnt_sel0` = 255 via 510 accepts: the next selector-0 accept wraps it to 0. With the macro undefined, both counters read 0 throughout.
- Assert `reset` during HOLD: next cycle state is IDLE, selector 0, counters 0, `stall` 0.

Source files
------------

// File: rtl/demux_l1_pkg.sv
// Shared types and defaults for the layer-1 demux selector scheduler.
package demux_l1_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StActive = 2'd1,
    StHold   = 2'd2
  } state_e;

  localparam int unsigned IDLE_TO_DEFAULT = 4;

endpackage

// File: rtl/demux_l1_idle_timer.sv
// Idle-gap counter: counts consecutive idle cycles and flags the last one before timeout.
module demux_l1_idle_timer
  import demux_l1_pkg::*;
#(
  parameter int unsigned IDLE_TO = IDLE_TO_DEFAULT
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic timeout_o
);

  logic [3:0] idle_q, idle_d;

  assign timeout_o = (idle_q == 4'(IDLE_TO - 1));

  // Wrap back to zero on the timeout cycle so the next ACTIVE stint starts clean.
  always_comb begin
    idle_d = idle_q;
    if (clr_i) begin
      idle_d = '0;
    end else if (inc_i) begin
      idle_d = timeout_o ? 4'd0 : idle_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end

endmodule

// File: rtl/demux_l1_sched.sv
// Selector scheduler for the layer-1 1:2 demux pair; control only, data bypasses it.
// Define DEMUX_L1_SCHED_CNT_EN to implement the per-selector routed-word counters.
module demux_l1_sched
  import demux_l1_pkg::*;
#(
  parameter int unsigned IDLE_TO = IDLE_TO_DEFAULT,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk_2f,
  input  logic             reset,
  input  logic             valid0,
  input  logic             valid1,
  input  logic             pause0,
  input  logic             pause1,
  input  logic             pause2,
  input  logic             pause3,
  output logic             selectorL1,
  output logic             validg0,
  output logic             validg1,
  output logic             stall,
  output logic [CNT_W-1:0] cnt_sel0,
  output logic [CNT_W-1:0] cnt_sel1
);

  state_e state_q, state_d;
  logic   sel_q, sel_d;
  logic   blocked, any_v, accept;
  logic   idle_clr, idle_inc, timeout;

  // Only the output pair the selector currently points at can block.
  assign blocked = sel_q ? (pause1 | pause3) : (pause0 | pause2);
  assign any_v   = valid0 | valid1;
  assign accept  = any_v & ~blocked;

  assign selectorL1 = sel_q;
  assign validg0    = valid0 & ~blocked & ~reset;
  assign validg1    = valid1 & ~blocked & ~reset;
  assign stall      = any_v & blocked & ~reset;

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    idle_clr = 1'b1;
    idle_inc = 1'b0;
    unique case (state_q)
      StIdle: begin
        sel_d = 1'b0;
        if (accept) begin
          state_d = StActive;
          sel_d   = 1'b1;
        end else if (any_v) begin
          state_d = StHold;
        end
      end
      StActive: begin
        if (accept) begin
          sel_d = ~sel_q;
        end else if (any_v) begin
          state_d = StHold;
        end else begin
          idle_clr = 1'b0;
          idle_inc = 1'b1;
          if (timeout) begin
            state_d = StIdle;
            sel_d   = 1'b0;
          end
        end
      end
      StHold: begin
        if (!blocked) begin
          state_d = StActive;
          if (any_v) begin
            sel_d = ~sel_q;
          end
        end
      end
      default: begin
        state_d = StIdle;
        sel_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_2f) begin
    if (reset) begin
      state_q <= StIdle;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  demux_l1_idle_timer #(
    .IDLE_TO(IDLE_TO)
  ) u_idle_timer (
    .clk_i    (clk_2f),
    .reset_i  (reset),
    .clr_i    (idle_clr),
    .inc_i    (idle_inc),
    .timeout_o(timeout)
  );

`ifdef DEMUX_L1_SCHED_CNT_EN
  logic [CNT_W-1:0] cnt0_q, cnt1_q;

  // The counter credited is the one for the selector value before the toggle.
  always_ff @(posedge clk_2f) begin
    if (reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (accept) begin
      if (sel_q) begin
        cnt1_q <= cnt1_q + CNT_W'(1);
      end else begin
        cnt0_q <= cnt0_q + CNT_W'(1);
      end
    end
  end

  assign cnt_sel0 = cnt0_q;
  assign cnt_sel1 = cnt1_q;
`else
  assign cnt_sel0 = '0;
  assign cnt_sel1 = '0;
`endif

endmodule

// File: tb/tb_demux_l1_sched.sv
// Self-checking bench for demux_l1_sched: directed scenarios then randomized traffic.
module tb_demux_l1_sched;

  localparam int unsigned IdleTo  = 4;
  localparam int unsigned CntW    = 8;
  localparam int unsigned CntMask = (1 << CntW) - 1;
`ifdef DEMUX_L1_SCHED_CNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic            clk_2f = 1'b0;
  logic            reset, valid0, valid1, pause0, pause1, pause2, pause3;
  logic            selectorL1, validg0, validg1, stall;
  logic [CntW-1:0] cnt_sel0, cnt_sel1;

  demux_l1_sched #(
    .IDLE_TO(IdleTo),
    .CNT_W  (CntW)
  ) dut (
    .clk_2f    (clk_2f),
    .reset     (reset),
    .valid0    (valid0),
    .valid1    (valid1),
    .pause0    (pause0),
    .pause1    (pause1),
    .pause2    (pause2),
    .pause3    (pause3),
    .selectorL1(selectorL1),
    .validg0   (validg0),
    .validg1   (validg1),
    .stall     (stall),
    .cnt_sel0  (cnt_sel0),
    .cnt_sel1  (cnt_sel1)
  );

  always #5 clk_2f = ~clk_2f;

  int passes = 0;
  int fails  = 0;
  int total  = 0;

  // Reference model: mode 0 = idle, 1 = active, 2 = hold.
  bit          m_sel;
  int          m_mode;
  int          m_idle_run;
  int unsigned m_cnt[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_sel      = 1'b0;
    m_mode     = 0;
    m_idle_run = 0;
    m_cnt[0]   = 0;
    m_cnt[1]   = 0;
  endfunction

  function automatic void model_edge(input bit v0, input bit v1, input bit [3:0] p,
                                     input bit rst);
    bit any, blk;
    if (rst) begin
      model_reset();
      return;
    end
    any = v0 | v1;
    blk = m_sel ? (p[1] | p[3]) : (p[0] | p[2]);
    if (any && !blk) begin
      m_cnt[m_sel] = (m_cnt[m_sel] + 1) & CntMask;
      m_sel        = ~m_sel;
      m_mode       = 1;
      m_idle_run   = 0;
    end else if (any) begin
      m_mode     = 2;
      m_idle_run = 0;
    end else if (m_mode == 1) begin
      m_idle_run++;
      if (m_idle_run == IdleTo) begin
        m_mode     = 0;
        m_sel      = 1'b0;
        m_idle_run = 0;
      end
    end else if (m_mode == 2 && !blk) begin
      m_mode = 1;
    end
  endfunction

  task automatic step(input bit v0, input bit v1, input bit [3:0] p, input bit rst,
                      input string tag);
    bit blk;
    valid0 = v0;
    valid1 = v1;
    pause0 = p[0];
    pause1 = p[1];
    pause2 = p[2];
    pause3 = p[3];
    reset  = rst;
    #1;
    blk = m_sel ? (p[1] | p[3]) : (p[0] | p[2]);
    check({tag, ":validg0"}, 32'(validg0), 32'(v0 & ~blk & ~rst));
    check({tag, ":validg1"}, 32'(validg1), 32'(v1 & ~blk & ~rst));
    check({tag, ":stall"}, 32'(stall), 32'((v0 | v1) & blk & ~rst));
    check({tag, ":sel"}, 32'(selectorL1), 32'(m_sel));
    check({tag, ":cnt0"}, 32'(cnt_sel0), CntEn ? m_cnt[0] : 0);
    check({tag, ":cnt1"}, 32'(cnt_sel1), CntEn ? m_cnt[1] : 0);
    check({tag, ":state"}, 32'(dut.state_q), 32'(m_mode));
    @(posedge clk_2f);
    model_edge(v0, v1, p, rst);
    @(negedge clk_2f);
  endtask

  initial begin
    reset  = 1'b1;
    valid0 = 1'b0;
    valid1 = 1'b0;
    pause0 = 1'b0;
    pause1 = 1'b0;
    pause2 = 1'b0;
    pause3 = 1'b0;
    model_reset();
    @(posedge clk_2f);
    @(negedge clk_2f);

    step(1'b1, 1'b0, 4'b0000, 1'b1, "rst");
    step(1'b0, 1'b0, 4'b0000, 1'b1, "rst2");

    // Both lanes valid, no pause: selector alternates, two words per counter.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 4'b0000, 1'b0, "tp1");
    check("tp1_cnt0_final", 32'(cnt_sel0), CntEn ? 2 : 0);
    check("tp1_cnt1_final", 32'(cnt_sel1), CntEn ? 2 : 0);

    // Back-pressure on the selected pair holds the word and the selector.
    step(1'b1, 1'b0, 4'b0000, 1'b0, "tp2_pre");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'b1000, 1'b0, "tp2_hold");
    check("tp2_state_hold", 32'(dut.state_q), 2);
    check("tp2_sel_held", 32'(selectorL1), 1);
    step(1'b1, 1'b0, 4'b0000, 1'b0, "tp2_rel");
    check("tp2_sel_after", 32'(selectorL1), 0);

    // Idle gap realigns the selector.
    step(1'b1, 1'b0, 4'b0000, 1'b0, "tp3_acc");
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'b0000, 1'b0, "tp3_idle");
    check("tp3_state_idle", 32'(dut.state_q), 0);
    check("tp3_sel_zero", 32'(selectorL1), 0);
    step(1'b1, 1'b0, 4'b0000, 1'b0, "tp3_next");

    // Pause on the off pair is ignored.
    step(1'b1, 1'b0, 4'b0001, 1'b0, "tp4_offpair");
    step(1'b0, 1'b1, 4'b0100, 1'b0, "tp4_onpair");

    // Counter wrap after 510 accepts from reset.
    step(1'b0, 1'b0, 4'b0000, 1'b1, "tp5_rst");
    for (int i = 0; i < 510; i++) step(1'b1, 1'b0, 4'b0000, 1'b0, "tp5_pre");
    check("tp5_cnt0_255", 32'(cnt_sel0), CntEn ? 255 : 0);
    step(1'b1, 1'b0, 4'b0000, 1'b0, "tp5_wrap");
    check("tp5_cnt0_wrap", 32'(cnt_sel0), 0);
    check("tp5_cnt1_255", 32'(cnt_sel1), CntEn ? 255 : 0);

    // Reset while holding drops the pending word.
    step(1'b1, 1'b0, 4'b1000, 1'b0, "tp6_hold");
    check("tp6_state_hold", 32'(dut.state_q), 2);
    step(1'b1, 1'b0, 4'b1000, 1'b1, "tp6_rst");
    check("tp6_state_idle", 32'(dut.state_q), 0);
    check("tp6_sel_zero", 32'(selectorL1), 0);
    check("tp6_cnt0_zero", 32'(cnt_sel0), 0);
    check("tp6_cnt1_zero", 32'(cnt_sel1), 0);
    step(1'b0, 1'b0, 4'b0000, 1'b0, "tp6_after");

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bit [3:0] p;
      for (int k = 0; k < 4; k++) p[k] = ($urandom_range(0, 3) == 0);
      step($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, p,
           $urandom_range(0, 199) == 0, "rand");
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
